shared_bus_sched: RTL and testbench

Round-robin scheduler for one shared W-bit bus driven by N requesters. The block grants the bus to one requester at a time and gates that requester's drive enable. It enforces a programmable turnaround gap between one driver releasing the bus and the next driver enabling, so two drivers never overlap. It sits between the requester agents and the bus resolution point, and owns the only drive-enable per requester.

---
 rtl/shared_bus_sched.sv | 155 +++++++++++++++
 tb/tb_shared_bus_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_bus_sched.sv
// Round-robin scheduler for one shared W-bit bus with a programmable turnaround gap.
// Optional idle-bus keeper register: define SHARED_BUS_KEEPER_EN.
module shared_bus_sched #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int TURN     = 2,
    parameter int HOLD_MAX = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   grant,
    output logic           drv_en,
    output logic [W-1:0]   bus_data,
    output logic           busy,
    output logic [2:0]     owner
);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_TURN} state_t;

    localparam logic [3:0] N4    = 4'(N);
    localparam logic [3:0] TURN4 = 4'(TURN);
    localparam logic [7:0] HOLD8 = 8'(HOLD_MAX);

    state_t       r_state, w_state_nxt;
    logic [N-1:0] r_grant, w_grant_nxt;
    logic [2:0]   r_owner, w_owner_nxt;
    logic [2:0]   r_ptr, w_ptr_nxt;
    logic [7:0]   r_beat, w_beat_nxt;
    logic [3:0]   r_tcnt, w_tcnt_nxt;
    logic         r_busy, w_busy_nxt;
    logic [2:0]   w_sel;
    logic         w_found;
    logic         w_end;
    logic [3:0]   w_sum;
    logic [3:0]   w_sel_inc;
    logic [7:0]   w_req8;
    logic [W-1:0] w_data [8];
    logic [W-1:0] w_drv_val;

    // Pad requests and data slices to 8 entries so a 3-bit index always fits.
    assign w_req8 = 8'(req);
    for (genvar g = 0; g < 8; g++) begin : g_pad
        if (g < N) begin : g_used
            assign w_data[g] = data_in[g*W +: W];
        end else begin : g_unused
            assign w_data[g] = '0;
        end
    end

    assign w_drv_val = w_data[r_owner];

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + 4'(k);
            if (w_sum >= N4) w_sum = w_sum - N4;
            if (!w_found && w_req8[w_sum[2:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[2:0];
            end
        end
    end

    assign w_sel_inc = {1'b0, w_sel} + 4'd1;
    // Both exit conditions fold into one term, so a coincident drop and limit exits once.
    assign w_end     = !w_req8[r_owner] || (r_beat >= HOLD8);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_beat_nxt  = r_beat;
        w_tcnt_nxt  = r_tcnt;
        w_busy_nxt  = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_DRIVE;
                    w_grant_nxt = N'(1) << w_sel;
                    w_owner_nxt = w_sel;
                    w_beat_nxt  = 8'd1;
                    w_ptr_nxt   = (w_sel_inc >= N4) ? 3'd0 : w_sel_inc[2:0];
                    w_busy_nxt  = 1'b1;
                end
            end
            S_DRIVE: begin
                if (w_end) begin
                    w_grant_nxt = '0;
                    if (TURN == 0) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_TURN;
                        w_tcnt_nxt  = TURN4;
                    end
                end else begin
                    w_beat_nxt = (r_beat < HOLD8) ? r_beat + 8'd1 : r_beat;
                end
            end
            S_TURN: begin
                w_tcnt_nxt = r_tcnt - 4'd1;
                if (r_tcnt <= 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_beat  <= '0;
            r_tcnt  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_beat  <= w_beat_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign grant  = r_grant;
    assign drv_en = |r_grant;
    assign busy   = r_busy;
    assign owner  = r_owner;

`ifdef SHARED_BUS_KEEPER_EN
    logic [W-1:0] r_keep;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_keep <= '0;
        else if (r_state == S_DRIVE) r_keep <= w_drv_val;
    end
    assign bus_data = drv_en ? w_drv_val : r_keep;
`else
    assign bus_data = drv_en ? w_drv_val : '0;
`endif

endmodule

// File: tb/tb_shared_bus_sched.sv
// Bench for shared_bus_sched: a TURN=2 and a TURN=0 instance driven in parallel,
// checked each cycle against a grant-level reference model plus directed timing checks.
module tb_shared_bus_sched;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TA = 2;
    localparam int HM = 3;
`ifdef SHARED_BUS_KEEPER_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b0;
    logic [N-1:0]   req     = '0;
    logic [N*W-1:0] data_in = '0;

    logic [N-1:0] grant_a, grant_b;
    logic         drv_a, drv_b, busy_a, busy_b;
    logic [2:0]   own_a, own_b;
    logic [W-1:0] bus_a, bus_b;

    always #5 clk = ~clk;

    shared_bus_sched #(.N(N), .W(W), .TURN(TA), .HOLD_MAX(HM)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .grant(grant_a), .drv_en(drv_a), .bus_data(bus_a), .busy(busy_a), .owner(own_a)
    );

    shared_bus_sched #(.N(N), .W(W), .TURN(0), .HOLD_MAX(HM)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .grant(grant_b), .drv_en(drv_b), .bus_data(bus_b), .busy(busy_b), .owner(own_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Grant-level model: current owner (-1 = none), cycles granted, quiet cycles left.
    int           m_own   [2];
    int           m_len   [2];
    int           m_quiet [2];
    int           m_ptr   [2];
    int           m_last  [2];
    logic [W-1:0] m_keep  [2];

    // Grant-sequence recorder.
    int ord_q [2][$];
    int len_q [2][$];
    int gap_q [2][$];
    int rc_len  [2];
    int rc_gap  [2];
    bit rc_seen [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] slice(input int i);
        return data_in[i*W +: W];
    endfunction

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            m_own[m] = -1; m_len[m] = 0; m_quiet[m] = 0;
            m_ptr[m] = 0;  m_last[m] = 0; m_keep[m] = '0;
        end
    endtask

    task automatic m_step(input int m);
        int tv;
        logic [N-1:0] r;
        r  = req;
        tv = (m == 0) ? TA : 0;
        if (m_own[m] >= 0) begin
            m_keep[m] = slice(m_own[m]);
            if (!r[m_own[m]] || m_len[m] == HM) begin
                m_own[m]   = -1;
                m_quiet[m] = tv;
            end else begin
                m_len[m]++;
            end
        end else if (m_quiet[m] > 0) begin
            m_quiet[m]--;
        end else if (r != '0) begin
            for (int k = 0; k < N; k++)
                if (m_own[m] < 0 && r[(m_ptr[m] + k) % N]) m_own[m] = (m_ptr[m] + k) % N;
            m_last[m] = m_own[m];
            m_len[m]  = 1;
            m_ptr[m]  = (m_own[m] + 1) % N;
        end
    endtask

    task automatic chk_dut(input int m, input logic [N-1:0] g, input logic de, input logic bz,
                           input logic [2:0] ow, input logic [W-1:0] bd);
        string p;
        logic [N-1:0] eg;
        logic [W-1:0] eb;
        p  = (m == 0) ? "a_" : "b_";
        eg = (m_own[m] >= 0) ? (N'(1) << m_own[m]) : '0;
        eb = (m_own[m] >= 0) ? slice(m_own[m]) : (KEEP ? m_keep[m] : '0);
        chk({p, "grant"},  32'(g),  32'(eg));
        chk({p, "drv_en"}, 32'(de), 32'(m_own[m] >= 0));
        chk({p, "busy"},   32'(bz), 32'((m_own[m] >= 0) || (m_quiet[m] > 0)));
        chk({p, "owner"},  32'(ow), 32'(m_last[m]));
        chk({p, "bus"},    32'(bd), 32'(eb));
        chk({p, "onehot"}, 32'($onehot0(g)), 32'd1);
    endtask

    task automatic rec_clear();
        for (int m = 0; m < 2; m++) begin
            ord_q[m].delete(); len_q[m].delete(); gap_q[m].delete();
            rc_len[m] = 0; rc_gap[m] = 0; rc_seen[m] = 1'b0;
        end
    endtask

    task automatic rec(input int m, input logic [N-1:0] g);
        int idx;
        idx = -1;
        if (g != '0) begin
            if (rc_len[m] == 0) begin
                for (int i = 0; i < N; i++) if (g[i]) idx = i;
                ord_q[m].push_back(idx);
                if (rc_seen[m]) gap_q[m].push_back(rc_gap[m]);
                rc_seen[m] = 1'b1;
                rc_gap[m]  = 0;
            end
            rc_len[m]++;
        end else begin
            if (rc_len[m] > 0) begin
                len_q[m].push_back(rc_len[m]);
                rc_len[m] = 0;
            end
            rc_gap[m]++;
        end
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] d);
        @(negedge clk);
        req     = r;
        data_in = d;
        @(posedge clk);
        m_step(0);
        m_step(1);
        #1;
        chk_dut(0, grant_a, drv_a, busy_a, own_a, bus_a);
        chk_dut(1, grant_b, drv_b, busy_b, own_b, bus_b);
        rec(0, grant_a);
        rec(1, grant_b);
    endtask

    // Reset is asserted mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_grant_a", 32'(grant_a), 32'd0);
        chk("rst_drv_a",   32'(drv_a),   32'd0);
        chk("rst_bus_a",   32'(bus_a),   32'd0);
        chk("rst_busy_a",  32'(busy_a),  32'd0);
        chk("rst_owner_a", 32'(own_a),   32'd0);
        chk("rst_grant_b", 32'(grant_b), 32'd0);
        chk("rst_bus_b",   32'(bus_b),   32'd0);
        m_reset();
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        rec_clear();
    endtask

    function automatic int qget(input int m, input int sel, input int i);
        if (sel == 0) return (i < ord_q[m].size()) ? ord_q[m][i] : -1;
        if (sel == 1) return (i < len_q[m].size()) ? len_q[m][i] : -1;
        return (i < gap_q[m].size()) ? gap_q[m][i] : -1;
    endfunction

    initial begin
        logic [N-1:0]   r;
        logic [N*W-1:0] d;
        int             exp_ord [5];
        exp_ord = '{0, 1, 2, 3, 0};

        // Power-on reset.
        m_reset();
        rec_clear();
        #2;
        chk("por_grant", 32'(grant_a), 32'd0);
        chk("por_bus",   32'(bus_a),   32'd0);
        chk("por_busy",  32'(busy_a),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all requesters held.
        for (int c = 0; c < 32; c++) cycle(4'b1111, 32'h4433_2211);
        chk("rr_count_a", 32'(ord_q[0].size() >= 5), 32'd1);
        chk("rr_count_b", 32'(ord_q[1].size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("rr_order_a", 32'(qget(0, 0, i)), 32'(exp_ord[i]));
            chk("rr_order_b", 32'(qget(1, 0, i)), 32'(exp_ord[i]));
        end
        for (int i = 0; i < len_q[0].size(); i++) chk("rr_len_a", 32'(len_q[0][i]), 32'(HM));
        for (int i = 0; i < gap_q[0].size(); i++) chk("rr_gap_a", 32'(gap_q[0][i]), 32'(TA + 1));
        for (int i = 0; i < gap_q[1].size(); i++) chk("rr_gap_b", 32'(gap_q[1][i]), 32'd1);

        // Single requester, two request cycles.
        do_reset();
        d = 32'h0000_A500;
        cycle(4'b0010, d);
        chk("s1_grant", 32'(grant_a), 32'h2);
        chk("s1_bus",   32'(bus_a),   32'hA5);
        cycle(4'b0010, d);
        chk("s1_grant2", 32'(grant_a), 32'h2);
        cycle(4'b0000, d);
        chk("s1_rel_drv",  32'(drv_a),  32'd0);
        chk("s1_rel_busy", 32'(busy_a), 32'd1);
        cycle(4'b0000, d);
        chk("s1_turn_busy", 32'(busy_a), 32'd1);
        cycle(4'b0000, d);
        chk("s1_idle_busy", 32'(busy_a), 32'd0);

        // Request drop coincides with the hold limit.
        do_reset();
        for (int c = 0; c < 3; c++) cycle(4'b0011, 32'h0000_BB11);
        for (int c = 0; c < 6; c++) cycle(4'b0010, 32'h0000_BB11);
        chk("se_order0", 32'(qget(0, 0, 0)), 32'd0);
        chk("se_order1", 32'(qget(0, 0, 1)), 32'd1);
        chk("se_len",    32'(qget(0, 1, 0)), 32'(HM));
        chk("se_gap",    32'(qget(0, 2, 0)), 32'(TA + 1));

        // Reset in the middle of a grant.
        do_reset();
        cycle(4'b0100, 32'h00C7_0000);
        cycle(4'b0100, 32'h00C7_0000);
        chk("mr_pre_grant", 32'(grant_a), 32'h4);
        do_reset();
        cycle(4'b0101, 32'h00C7_0099);
        chk("mr_post_grant", 32'(grant_a), 32'h1);
        chk("mr_post_owner", 32'(own_a),   32'd0);
        for (int c = 0; c < 6; c++) cycle(4'b0000, 32'h00C7_0099);

        // Idle bus value after a drive (keeper or zero).
        do_reset();
        cycle(4'b0100, 32'h003C_0000);
        cycle(4'b0000, 32'h003C_0000);
        for (int c = 0; c < 3; c++) begin
            cycle(4'b0000, 32'hFFFF_FFFF);
            chk("kp_idle_bus", 32'(bus_a), KEEP ? 32'h3C : 32'h0);
        end

        // Zero-turnaround gap.
        do_reset();
        for (int c = 0; c < 10; c++) cycle(4'b0011, 32'h0000_2211);
        chk("t0_order0", 32'(qget(1, 0, 0)), 32'd0);
        chk("t0_order1", 32'(qget(1, 0, 1)), 32'd1);
        chk("t0_gap",    32'(qget(1, 2, 0)), 32'd1);

        // Randomised traffic with sticky requests.
        do_reset();
        r = '0;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            d = {$urandom};
            cycle(r, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
